control_pc: RTL
===============

# control_pc

Program-counter sequencer for the pipeline's fetch stage. Owns the 11-bit PC register, drives it to instruction memory and the PC incrementer (`sumador`), and takes `pc_incrementado` back as the default next PC. Each cycle it picks the next PC from three sources: increment, a branch/jump redirect from EX, or hold (for a stall or halt). It runs start/halt sequencing, raises the IF/ID flush request and counts fetches.

## Interface
- `ANCHO_PC`, 11, PC width. Must match `sumador` (11 bits, word-addressed memory, +1 per instruction).
- `PC_INICIAL`, 11'h000, PC value after reset and after restart from HALT.
- `clk` in 1: single clock. All state updates on rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `arrancar` in 1: start/restart request, level-sampled.
- `stall` in 1: hazard unit hold request.
- `salto` in 1: taken branch/jump resolved in EX.
- `dir_salto` in ANCHO_PC: redirect target, valid when `salto`=1.
- `halt` in 1: halt instruction decoded in ID.
- `pc_incrementado` in ANCHO_PC: from `sumador`, equals `pc_actual`+1 mod 2^11.
- `pc_actual` out ANCHO_PC: current PC, registered.
- `fetch_valido` out 1: the fetched word at `pc_actual` is valid.
- `flush` out 1: clear IF/ID at the next edge. Combinational.
- `estado` out 2: IDLE=00, RUN=01, STALL=10, HALT=11. Registered.
- `contador_fetch` out 16: PC-advance counter. Registered, saturating.

## Operation
- States are IDLE, RUN, STALL and HALT. Per-state priority is listed below. `salto` is accepted only in RUN or STALL.
- IDLE:
  - `arrancar`=1 -> RUN. PC is held at `PC_INICIAL` and `contador_fetch` is cleared.
  - All other inputs are ignored.
- RUN, priority `salto` > `stall` > `halt` > increment:
  - `salto`: `pc_actual`<=`dir_salto`, stay RUN, `flush`=1 this cycle.
  - `stall`: PC held -> STALL.
  - `halt`: PC held -> HALT.
  - Otherwise: `pc_actual`<=`pc_incrementado`.
- STALL, same priority order:
  - `salto`: load `dir_salto`, `flush`=1 -> RUN.
  - `stall`=1: hold, stay STALL.
  - `halt`=1 with `stall`=0: -> HALT, PC held.
  - Otherwise: `pc_actual`<=`pc_incrementado` -> RUN.
- HALT:
  - PC held. `salto`, `stall` and `halt` are ignored.
  - `arrancar`=1: `pc_actual`<=`PC_INICIAL`, `contador_fetch`<=0 -> RUN.
- `arrancar` is ignored in RUN and STALL.
- `fetch_valido` = (`estado`==RUN).
- `flush` = `salto` & (`estado`==RUN | `estado`==STALL). It is never asserted in IDLE or HALT.
- Arithmetic and width rules:
  - `pc_incrementado` and `dir_salto` are loaded verbatim, with no range check.
  - 11'h7FF wraps to 11'h000 through `sumador`; the controller does not special-case it.
- `contador_fetch` increments at every edge where the PC is loaded from `pc_incrementado` or `dir_salto`. It holds at 16'hFFFF.

## Timing
- `rst_n` low, asynchronous and immediate, including mid-operation:
  - `estado`=IDLE, `pc_actual`=`PC_INICIAL`, `contador_fetch`=0.
  - `fetch_valido`=0 and `flush`=0.
- `rst_n` is released synchronously by the upstream reset synchronizer. The first active edge follows.
- One-cycle latency for every input:
  - `salto` sampled at edge N gives `pc_actual`=`dir_salto` after edge N.
  - `flush` is high during the cycle before edge N, so the IF/ID clear coincides with the redirect load.
- A `salto` lasting several cycles is treated as one redirect per cycle. Each cycle reloads `dir_salto` and flushes.
- Any two or more of `salto`, `stall` and `halt` in the same cycle resolve strictly by the priority above:
  - `salto`+`stall` redirects and goes to RUN.
  - `stall`+`halt` stalls; the halt is re-evaluated after the stall drops.
- No combinational path from `pc_incrementado` to any output. The only combinational output is `flush`, from `salto` and `estado`.
- Restart: the edge that samples `arrancar` in IDLE or HALT produces RUN with `pc_actual`=`PC_INICIAL`. The first increment happens on the following edge.

## Test plan
- Reset, then `arrancar` pulse, then 5 free cycles: `pc_actual` = 0, 0, 1, 2, 3, 4, 5; `fetch_valido`=1 from the RUN cycle; `contador_fetch`=5.
- At `pc_actual`=3, assert `salto` with `dir_salto`=11'h120 for 1 cycle:
  - `flush`=1 that cycle only.
  - Next cycle `pc_actual`=11'h120, then 11'h121.
- `stall` for 3 cycles at `pc_actual`=7:
  - `estado`=STALL, PC stays 7, `fetch_valido`=0.
  - After release, `pc_actual`=8 and `estado`=RUN.
  - Repeat with `salto`=1 (`dir_salto`=11'h040) on the 2nd stall cycle: PC becomes 11'h040, `estado`=RUN.
- Same-cycle `stall`+`halt`: PC holds in STALL. When `stall` drops with `halt`=1: `estado`=HALT, PC held, `salto` ignored. `arrancar` then gives `pc_actual`=0, `contador_fetch`=0, RUN.
- `dir_salto`=11'h7FE then free-run: `pc_actual` = 7FE, 7FF, 000, 001. With the counter forced near top, `contador_fetch` saturates at FFFF.
- `rst_n` pulsed low mid-RUN, between clock edges:
  - Outputs go to reset values immediately, without waiting for a clock edge: IDLE, PC=0, counter 0.
  - `flush` stays low while `salto`=1 in IDLE.

Source files
------------

// File: rtl/control_pc.sv
// ---------------------------------------------------------------------------
// control_pc -- program-counter sequencer for the fetch stage.
//
// Owns the PC register and picks the next PC each cycle from one of three
// sources: the incremented PC coming back from the external adder, a
// branch/jump redirect resolved in EX, or hold (stall/halt/idle). Also runs
// the start/halt sequencing, raises the IF/ID flush request and counts PC
// advances.
//
// Ports
//   clk              in   single clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   arrancar         in   start/restart request (IDLE/HALT only)
//   stall            in   hazard-unit hold request
//   salto            in   taken branch/jump from EX
//   dir_salto        in   redirect target, valid with salto
//   halt             in   halt instruction decoded in ID
//   pc_incrementado  in   pc_actual + 1 from the external adder
//   pc_actual        out  current PC (registered)
//   fetch_valido     out  fetched word at pc_actual is valid (RUN)
//   flush            out  clear IF/ID at next edge (combinational)
//   estado           out  IDLE=00 RUN=01 STALL=10 HALT=11 (registered)
//   contador_fetch   out  saturating PC-advance counter (registered)
// ---------------------------------------------------------------------------
module control_pc #(
    parameter int unsigned           ANCHO_PC   = 11,
    parameter logic [ANCHO_PC-1:0]   PC_INICIAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arrancar,
    input  logic                stall,
    input  logic                salto,
    input  logic [ANCHO_PC-1:0] dir_salto,
    input  logic                halt,
    input  logic [ANCHO_PC-1:0] pc_incrementado,
    output logic [ANCHO_PC-1:0] pc_actual,
    output logic                fetch_valido,
    output logic                flush,
    output logic [1:0]          estado,
    output logic [15:0]         contador_fetch
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        HALT  = 2'b11
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [ANCHO_PC-1:0] pc_q, pc_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                avanza;     // PC loaded from the adder or a redirect
    logic                reinicia;   // restart clears the counter

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            pc_q     <= PC_INICIAL;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        avanza   = 1'b0;
        reinicia = 1'b0;
        flush    = 1'b0;

        unique case (estado_q)
            IDLE: begin
                if (arrancar) begin
                    estado_d = RUN;
                    pc_d     = PC_INICIAL;
                    reinicia = 1'b1;
                end
            end
            RUN: begin
                if (salto) begin
                    pc_d   = dir_salto;
                    avanza = 1'b1;
                    flush  = 1'b1;
                end else if (stall) begin
                    estado_d = STALL;
                end else if (halt) begin
                    estado_d = HALT;
                end else begin
                    pc_d   = pc_incrementado;
                    avanza = 1'b1;
                end
            end
            STALL: begin
                if (salto) begin
                    estado_d = RUN;
                    pc_d     = dir_salto;
                    avanza   = 1'b1;
                    flush    = 1'b1;
                end else if (stall) begin
                    estado_d = STALL;
                end else if (halt) begin
                    // halt seen while stalled is only honoured once stall drops
                    estado_d = HALT;
                end else begin
                    estado_d = RUN;
                    pc_d     = pc_incrementado;
                    avanza   = 1'b1;
                end
            end
            HALT: begin
                if (arrancar) begin
                    estado_d = RUN;
                    pc_d     = PC_INICIAL;
                    reinicia = 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase

        // Counter: cleared on restart, saturates at all-ones.
        cnt_d = cnt_q;
        if (reinicia)
            cnt_d = '0;
        else if (avanza && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    assign pc_actual      = pc_q;
    assign estado         = estado_q;
    assign contador_fetch = cnt_q;
    assign fetch_valido   = (estado_q == RUN);

endmodule
